// File: rtl/diff_pkg.sv
// Shared definitions for the delta-sample decoder: default widths, the
// decoder state type and the extended-precision add with range detection.
package diff_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_CNT_W = 16;

    // WAIT_KEY: no valid reference yet; RUN: reference is live.
    typedef enum logic {
        WAIT_KEY = 1'b0,
        RUN      = 1'b1
    } state_t;

    // Result of ref + delta: the modulo sum plus underflow/overflow flags.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] mod_sum;
        logic                 under;
        logic                 over;
    } add_res_t;

    // Unsigned reference plus sign-extended delta, evaluated two bits wider
    // than the sample so that both underflow and overflow are visible.
    function automatic add_res_t add_range(input logic [DEF_WIDTH-1:0] r,
                                           input logic [DEF_WIDTH-1:0] d);
        logic signed [DEF_WIDTH+1:0] s;
        add_res_t                    res;
        s = $signed({2'b00, r}) + $signed({{2{d[DEF_WIDTH-1]}}, d});
        res.mod_sum = s[DEF_WIDTH-1:0];
        res.under   = s[DEF_WIDTH+1];
        res.over    = !s[DEF_WIDTH+1] && s[DEF_WIDTH];
        return res;
    endfunction

endpackage

// File: rtl/diff_add_24bit.sv
// Combinational reference + delta adder with range flag.
// With DIFF_DECODER_SAT_EN defined the result is clamped to 0..all-ones;
// otherwise it wraps modulo 2^24 and no clamp logic exists.
module diff_add_24bit
    import diff_pkg::*;
(
    input  logic [DEF_WIDTH-1:0] i_ref,
    input  logic [DEF_WIDTH-1:0] i_delta,
    output logic [DEF_WIDTH-1:0] o_result,
    output logic                 o_range
);

    add_res_t w_res;

    assign w_res   = add_range(i_ref, i_delta);
    assign o_range = w_res.under || w_res.over;

`ifdef DIFF_DECODER_SAT_EN
    // Clamp out-of-range sums to the nearest representable sample.
    always_comb begin
        o_result = w_res.mod_sum;
        if (w_res.under) begin
            o_result = '0;
        end else if (w_res.over) begin
            o_result = '1;
        end
    end
`else
    // Plain modulo wrap: keep the low bits of the sum.
    always_comb begin
        o_result = w_res.mod_sum;
    end
`endif

endmodule

// File: rtl/diff_decoder_24bit.sv
// Delta-sample decoder: rebuilds absolute samples from two's-complement
// deltas, re-seeding on key beats. Valid/ready on both sides, one output
// register stage. Optional clamp mode: define DIFF_DECODER_SAT_EN.
// The adder is 24 bits wide; WIDTH is expected to stay at its default.
module diff_decoder_24bit
    import diff_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_key,
    output logic             out_wrap,
    output logic [CNT_W-1:0] drop_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_ref;
    logic [WIDTH-1:0]   r_data_p0;
    logic               r_key_p0;
    logic               r_wrap_p0;
    logic               r_vld_p0;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_load;
    logic               w_drop;
    logic [WIDTH-1:0]   w_data_nxt;
    logic               w_key_nxt;
    logic               w_wrap_nxt;
    logic [WIDTH-1:0]   w_add_result;
    logic               w_add_range;

    // The output register may reload in the same cycle it drains.
    assign w_in_ready = !rst && (!r_vld_p0 || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    diff_add_24bit u_add (
        .i_ref    (r_ref),
        .i_delta  (in_data),
        .o_result (w_add_result),
        .o_range  (w_add_range)
    );

    // Next-state and output-load decode for each accepted beat.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        w_data_nxt  = w_add_result;
        w_key_nxt   = 1'b0;
        w_wrap_nxt  = w_add_range;
        if (w_accept) begin
            if (in_key) begin
                w_load      = 1'b1;
                w_data_nxt  = in_data;
                w_key_nxt   = 1'b1;
                w_wrap_nxt  = 1'b0;
                w_state_nxt = RUN;
            end else if (r_state == WAIT_KEY) begin
                w_drop = 1'b1;
            end else begin
                w_load = 1'b1;
            end
        end
    end

    // State, reference and drop counter; drop count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WAIT_KEY;
            r_ref      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_ref <= w_data_nxt;
            end
            if (w_drop && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // ---- stage p0: registered output beat, held while stalled ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0  <= 1'b0;
            r_data_p0 <= '0;
            r_key_p0  <= 1'b0;
            r_wrap_p0 <= 1'b0;
        end else if (w_load) begin
            r_vld_p0  <= 1'b1;
            r_data_p0 <= w_data_nxt;
            r_key_p0  <= w_key_nxt;
            r_wrap_p0 <= w_wrap_nxt;
        end else if (out_ready) begin
            r_vld_p0 <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_vld_p0;
    assign out_data  = r_data_p0;
    assign out_key   = r_key_p0;
    assign out_wrap  = r_wrap_p0;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_diff_decoder_24bit.sv
// Directed bench for diff_decoder_24bit. A second instance with a 2-bit
// drop counter shares the stimulus to show counter saturation.
module tb_diff_decoder_24bit;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_key;
    logic [W-1:0]  in_data;
    logic          out_ready;

    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_key;
    logic          out_wrap;
    logic [15:0]   drop_cnt;

    logic          s_in_ready;
    logic          s_out_valid;
    logic [W-1:0]  s_out_data;
    logic          s_out_key;
    logic          s_out_wrap;
    logic [1:0]    s_drop_cnt;

    int n_vec = 0;
    int n_err = 0;

`ifdef DIFF_DECODER_SAT_EN
    localparam logic [W-1:0] EXP_OVF = 24'hFFFFFF;
    localparam logic [W-1:0] EXP_UNF = 24'h000000;
`else
    localparam logic [W-1:0] EXP_OVF = 24'h000000;
    localparam logic [W-1:0] EXP_UNF = 24'hFFFFFF;
`endif

    always #5 clk = ~clk;

    diff_decoder_24bit #(.WIDTH(W), .CNT_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_key   (out_key),
        .out_wrap  (out_wrap),
        .drop_cnt  (drop_cnt)
    );

    diff_decoder_24bit #(.WIDTH(W), .CNT_W(2)) u_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_data  (s_out_data),
        .out_key   (s_out_key),
        .out_wrap  (s_out_wrap),
        .drop_cnt  (s_drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic k, input logic [W-1:0] d);
        in_valid = v;
        in_key   = k;
        in_data  = d;
    endtask

    task automatic chk_beat(input string tag, input logic [W-1:0] d, input logic k, input logic wr);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"},  {8'd0, out_data},   {8'd0, d});
        chk({tag, "_key"},   {31'd0, out_key},   {31'd0, k});
        chk({tag, "_wrap"},  {31'd0, out_wrap},  {31'd0, wr});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        rst       = 1'b1;
        drive(1'b0, 1'b0, '0);
        cyc();
        cyc();
        // reset state, checked while rst is still high
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {8'd0, out_data},   32'd0);
        chk("rst_out_key",   {31'd0, out_key},   32'd0);
        chk("rst_out_wrap",  {31'd0, out_wrap},  32'd0);
        chk("rst_drop_cnt",  {16'd0, drop_cnt},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // basic reconstruction: key 1 then delta +2
        drive(1'b1, 1'b1, 24'h000001);
        cyc();
        chk_beat("basic_key", 24'h000001, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 24'h000002);
        cyc();
        chk_beat("basic_delta", 24'h000003, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0);
        cyc();
        chk("basic_idle_valid", {31'd0, out_valid}, 32'd0);

        // overflow: 0xFFFFFF + 1
        drive(1'b1, 1'b1, 24'hFFFFFF);
        cyc();
        chk_beat("ovf_key", 24'hFFFFFF, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 24'h000001);
        cyc();
        chk_beat("ovf_sum", EXP_OVF, 1'b0, 1'b1);
        chk("ovf_sum_small", {8'd0, s_out_data}, {8'd0, EXP_OVF});
        // underflow: 0 + (-1)
        drive(1'b1, 1'b1, 24'h000000);
        cyc();
        chk_beat("unf_key", 24'h000000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 24'hFFFFFF);
        cyc();
        chk_beat("unf_sum", EXP_UNF, 1'b0, 1'b1);
        // negative delta within range: 0x000010 + (-3)
        drive(1'b1, 1'b1, 24'h000010);
        cyc();
        drive(1'b1, 1'b0, 24'hFFFFFD);
        cyc();
        chk_beat("neg_delta", 24'h00000D, 1'b0, 1'b0);

        // zero delta twice
        drive(1'b1, 1'b1, 24'h123456);
        cyc();
        chk_beat("zero_key", 24'h123456, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 24'h000000);
        cyc();
        chk_beat("zero_d1", 24'h123456, 1'b0, 1'b0);
        cyc();
        chk_beat("zero_d2", 24'h123456, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0);
        cyc();

        // drops before key, with saturation of the 2-bit counter
        do_reset();
        drive(1'b1, 1'b0, 24'h000005);
        cyc();
        chk("drop1_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 1'b0, 24'h000006);
        cyc();
        chk("drop2_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 1'b0, 24'h000007);
        cyc();
        chk("drop3_valid", {31'd0, out_valid}, 32'd0);
        chk("drop3_cnt",   {16'd0, drop_cnt},  32'd3);
        cyc();
        cyc();
        chk("drop5_cnt",       {16'd0, drop_cnt},   32'd5);
        chk("drop5_small_cnt", {30'd0, s_drop_cnt}, 32'd3);
        chk("drop5_valid",     {31'd0, out_valid},  32'd0);
        drive(1'b1, 1'b1, 24'h000010);
        cyc();
        chk_beat("drop_key", 24'h000010, 1'b1, 1'b0);
        chk("drop_key_cnt", {16'd0, drop_cnt}, 32'd5);
        chk("drop_key_small_valid", {31'd0, s_out_valid}, 32'd1);
        drive(1'b0, 1'b0, '0);
        cyc();

        // backpressure: key 0x100 then +1,+1,+1 with out_ready 1,0,0,1
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 24'h000100);
        cyc();
        chk_beat("bp_key", 24'h000100, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 24'h000001);
        cyc();
        chk_beat("bp_d1", 24'h000101, 1'b0, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("bp_stall_in_ready1", {31'd0, in_ready}, 32'd0);
        cyc();
        chk_beat("bp_hold1", 24'h000101, 1'b0, 1'b0);
        chk("bp_stall_in_ready2", {31'd0, in_ready}, 32'd0);
        cyc();
        chk_beat("bp_hold2", 24'h000101, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        chk_beat("bp_d2", 24'h000102, 1'b0, 1'b0);
        cyc();
        chk_beat("bp_d3", 24'h000103, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0);
        cyc();
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);

        // reset while a beat is stalled
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 24'h000055);
        cyc();
        chk_beat("mid_key", 24'h000055, 1'b1, 1'b0);
        drive(1'b0, 1'b0, '0);
        rst = 1'b1;
        cyc();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_cnt",   {16'd0, drop_cnt},  32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 24'h000009);
        cyc();
        chk("mid_drop_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_drop_cnt",   {16'd0, drop_cnt},  32'd1);
        drive(1'b1, 1'b1, 24'h000007);
        cyc();
        chk_beat("mid_rekey", 24'h000007, 1'b1, 1'b0);
        drive(1'b0, 1'b0, '0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
